fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_types_pkg.sv | 26 ++
 rtl/fetch_unit.sv | 101 ++++++++++
 tb/tb_fetch_unit.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, fetch FSM states and the IF/ID pipeline record.
// Imported by the fetch stage and by anything that consumes the IF/ID register.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    typedef struct packed {
        word_t instr;
        word_t npc;
        logic  valid;
    } ifid_t;

    localparam word_t WORD_BYTES  = 32'd4;
    localparam ifid_t IFID_BUBBLE = '0;

    // Branch targets are forced onto a word boundary; low address bits are dropped.
    function automatic word_t word_align(input word_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: program counter, FETCH/HALTED control and the IF/ID
// pipeline register, with redirect, stall and flush handling from the hazard unit.
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t PC0 = 32'h00000000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        pc_en,
    input  logic        stall_ifid,
    input  logic        flush_ifid,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    input  logic        ihit,
    input  logic [31:0] iload,
    output logic        iREN,
    output logic [31:0] iaddr,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_npc,
    output logic        ifid_valid,
    output logic        fetch_halted,
    output logic [31:0] fetch_count
);

    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d;
    ifid_t        ifid_q, ifid_d;
    word_t        count_q, count_d;

    word_t pc_plus4;
    logic  fetching;
    logic  load_ifid;

    assign pc_plus4 = pc_q + WORD_BYTES;
    assign fetching = (state_q == FETCH);

    // An instruction arriving alongside a redirect is on the wrong path and is dropped.
    assign load_ifid = fetching && ihit && pc_en && !redirect;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (fetching && halt) begin
            state_d = HALTED;
        end
    end

    // Redirect overrides everything while fetching; HALTED freezes the PC entirely.
    always_comb begin
        pc_d = pc_q;
        if (fetching) begin
            if (redirect) begin
                pc_d = word_align(redirect_pc);
            end else if (ihit && pc_en && !stall_ifid) begin
                pc_d = pc_plus4;
            end
        end
    end

    always_comb begin
        ifid_d  = IFID_BUBBLE;
        count_d = count_q;
        if (flush_ifid) begin
            ifid_d = IFID_BUBBLE;
        end else if (stall_ifid) begin
            ifid_d = ifid_q;
        end else if (load_ifid) begin
            ifid_d.instr = iload;
            ifid_d.npc   = pc_plus4;
            ifid_d.valid = 1'b1;
            count_d      = count_q + 32'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample the same pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= FETCH;
            pc_q    <= PC0;
            ifid_q  <= IFID_BUBBLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ifid_q  <= ifid_d;
            count_q <= count_d;
        end
    end

    assign iREN         = fetching;
    assign iaddr        = pc_q;
    assign ifid_instr   = ifid_q.instr;
    assign ifid_npc     = ifid_q.npc;
    assign ifid_valid   = ifid_q.valid;
    assign fetch_halted = (state_q == HALTED);
    assign fetch_count  = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, miss, redirect, stall/flush,
// PC wrap, halt and reset recovery, each step checked against hand-computed values.
module tb_fetch_unit;

    logic        CLK;
    logic        nRST;
    logic        pc_en;
    logic        stall_ifid;
    logic        flush_ifid;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        ihit;
    logic [31:0] iload;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_npc;
    logic        ifid_valid;
    logic        fetch_halted;
    logic [31:0] fetch_count;

    int tests_run;
    int tests_failed;

    fetch_unit #(.PC0(32'h00000000)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .pc_en        (pc_en),
        .stall_ifid   (stall_ifid),
        .flush_ifid   (flush_ifid),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .halt         (halt),
        .ihit         (ihit),
        .iload        (iload),
        .iREN         (iREN),
        .iaddr        (iaddr),
        .ifid_instr   (ifid_instr),
        .ifid_npc     (ifid_npc),
        .ifid_valid   (ifid_valid),
        .fetch_halted (fetch_halted),
        .fetch_count  (fetch_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        pc_en       = 1'b1;
        stall_ifid  = 1'b0;
        flush_ifid  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        halt        = 1'b0;
        ihit        = 1'b0;
        iload       = 32'h0;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] instr, input logic [31:0] npc,
                              input logic valid);
        check({tag, ".instr"}, ifid_instr, instr);
        check({tag, ".npc"},   ifid_npc,   npc);
        check({tag, ".valid"}, {31'b0, ifid_valid}, {31'b0, valid});
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        idle_inputs();
        nRST = 1'b0;
        #12;

        // Reset state
        check("rst.iaddr", iaddr, 32'h0);
        check("rst.iREN", {31'b0, iREN}, 32'd1);
        check("rst.halted", {31'b0, fetch_halted}, 32'd0);
        check("rst.count", fetch_count, 32'd0);
        check_ifid("rst", 32'h0, 32'h0, 1'b0);
        nRST = 1'b1;
        #5;

        // Sequential fetch A,B,C,D
        ihit = 1'b1;
        iload = 32'hAAAA0001;
        step();
        check_ifid("seqA", 32'hAAAA0001, 32'h4, 1'b1);
        check("seqA.iaddr", iaddr, 32'h4);
        iload = 32'hBBBB0002;
        step();
        check_ifid("seqB", 32'hBBBB0002, 32'h8, 1'b1);
        check("seqB.iaddr", iaddr, 32'h8);
        iload = 32'hCCCC0003;
        step();
        check_ifid("seqC", 32'hCCCC0003, 32'hC, 1'b1);
        check("seqC.iaddr", iaddr, 32'hC);
        check("seqC.count", fetch_count, 32'd3);
        iload = 32'hDDDD0004;
        step();
        check("seqD.iaddr", iaddr, 32'h10);
        check("seqD.count", fetch_count, 32'd4);

        // Miss: ihit=0 for 4 cycles
        ihit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("miss.iaddr", iaddr, 32'h10);
            check("miss.valid", {31'b0, ifid_valid}, 32'd0);
            check("miss.count", fetch_count, 32'd4);
        end

        // Redirect to 0x20 without ihit
        redirect = 1'b1;
        redirect_pc = 32'h00000020;
        step();
        check("redir20.iaddr", iaddr, 32'h20);

        // Redirect with ihit at 0x20: unaligned target, instruction discarded
        ihit = 1'b1;
        iload = 32'h12345678;
        redirect_pc = 32'h00000203;
        step();
        check("redir200.iaddr", iaddr, 32'h200);
        check_ifid("redir200", 32'h0, 32'h0, 1'b0);
        check("redir200.count", fetch_count, 32'd4);

        // Load E at 0x200
        redirect = 1'b0;
        iload = 32'hEEEE0005;
        step();
        check_ifid("loadE", 32'hEEEE0005, 32'h204, 1'b1);
        check("loadE.iaddr", iaddr, 32'h204);
        check("loadE.count", fetch_count, 32'd5);

        // Stall alone: IF/ID and PC hold
        stall_ifid = 1'b1;
        iload = 32'h99999999;
        step();
        check_ifid("stall", 32'hEEEE0005, 32'h204, 1'b1);
        check("stall.iaddr", iaddr, 32'h204);
        check("stall.count", fetch_count, 32'd5);

        // Stall and flush together: flush wins
        flush_ifid = 1'b1;
        step();
        check_ifid("stallflush", 32'h0, 32'h0, 1'b0);
        check("stallflush.iaddr", iaddr, 32'h204);
        check("stallflush.count", fetch_count, 32'd5);

        // pc_en low with ihit: PC holds, bubble
        stall_ifid = 1'b0;
        flush_ifid = 1'b0;
        pc_en = 1'b0;
        step();
        check_ifid("pcen0", 32'h0, 32'h0, 1'b0);
        check("pcen0.iaddr", iaddr, 32'h204);
        pc_en = 1'b1;

        // PC wrap at 0xFFFFFFFC
        ihit = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'hFFFFFFFC;
        step();
        check("wrap.pre", iaddr, 32'hFFFFFFFC);
        redirect = 1'b0;
        ihit = 1'b1;
        iload = 32'hFFFF0006;
        step();
        check_ifid("wrap", 32'hFFFF0006, 32'h0, 1'b1);
        check("wrap.iaddr", iaddr, 32'h0);
        check("wrap.count", fetch_count, 32'd6);

        // Halt with ihit at 0x40
        ihit = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h00000040;
        step();
        redirect = 1'b0;
        ihit = 1'b1;
        halt = 1'b1;
        iload = 32'h66660007;
        step();
        check_ifid("halt", 32'h66660007, 32'h44, 1'b1);
        check("halt.halted", {31'b0, fetch_halted}, 32'd1);
        check("halt.iREN", {31'b0, iREN}, 32'd0);
        check("halt.iaddr", iaddr, 32'h44);
        check("halt.count", fetch_count, 32'd7);

        // In HALTED: redirect ignored, bubbles, count frozen
        halt = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h00000100;
        step();
        check("halted.iaddr", iaddr, 32'h44);
        check_ifid("halted", 32'h0, 32'h0, 1'b0);
        check("halted.count", fetch_count, 32'd7);
        check("halted.state", {31'b0, fetch_halted}, 32'd1);
        redirect = 1'b0;
        step();
        check("halted2.iaddr", iaddr, 32'h44);
        check("halted2.count", fetch_count, 32'd7);

        // Asynchronous reset mid-halt, then resume fetching
        #2;
        nRST = 1'b0;
        #1;
        check("arst.iaddr", iaddr, 32'h0);
        check("arst.halted", {31'b0, fetch_halted}, 32'd0);
        check("arst.iREN", {31'b0, iREN}, 32'd1);
        check("arst.count", fetch_count, 32'd0);
        #2;
        nRST = 1'b1;
        iload = 32'h77770008;
        step();
        check_ifid("resume", 32'h77770008, 32'h4, 1'b1);
        check("resume.iaddr", iaddr, 32'h4);
        check("resume.count", fetch_count, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
